serial_alu_ctrl: RTL and testbench

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_bit_slice.sv | 31 +++
 rtl/serial_alu_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_alu_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants and FSM state encoding for the serial ALU
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - one-bit combinational ALU slice (add/sub/and/or)
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       x0,
  input  logic       x1,
  input  logic       cin,
  input  logic [1:0] s,
  output logic       r,
  output logic       co
);

  logic y;

  // Subtraction is a + ~b + 1; the +1 arrives as the initial carry-in.
  always_comb begin
    y  = (s == OP_SUB) ? ~x1 : x1;
    r  = 1'b0;
    co = 1'b0;
    case (s)
      OP_ADD, OP_SUB: begin
        r  = x0 ^ y ^ cin;
        co = (x0 & y) | (x0 & cin) | (y & cin);
      end
      OP_AND: r = x0 & x1;
      OP_OR:  r = x0 | x1;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial ALU with valid/ready handshake; optional zero flag via SERIAL_ALU_ZFLAG_EN
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             cout
`ifdef SERIAL_ALU_ZFLAG_EN
  ,output logic            zero
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t          state, state_nxt;
  logic [1:0]      op;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            slice_r, slice_co;
  logic            last;
  logic            cout_fin;

  assign last = (cnt == CW'(WIDTH - 1));

  // Operands are shifted right each RUN cycle so the slice always sees bit 0.
  alu_bit_slice u_slice (
    .x0  (ra[0]),
    .x1  (rb[0]),
    .cin (carry),
    .s   (op),
    .r   (slice_r),
    .co  (slice_co)
  );

  // Final carry-out becomes a borrow for SUB and is meaningless for logic ops.
  always_comb begin
    cout_fin = 1'b0;
    case (op)
      OP_ADD:  cout_fin = slice_co;
      OP_SUB:  cout_fin = ~slice_co;
      default: cout_fin = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; in_ready is low in DONE so a consume edge never also accepts.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request on accept, then shift one result bit in from the top per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op    <= OP_ADD;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      R     <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= s;
            ra    <= a;
            rb    <= b;
            cnt   <= '0;
            carry <= (s == OP_SUB);
            cout  <= 1'b0;
          end
        end
        RUN: begin
          R     <= {slice_r, R[WIDTH-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= slice_co;
          cnt   <= cnt + CW'(1);
          if (last) cout <= cout_fin;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ALU_ZFLAG_EN
  assign zero = (state == DONE) && (R == '0);
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb/tb_serial_alu_ctrl.sv - randomized self-checking bench for serial_alu_ctrl against an arithmetic model
module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       s;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             cout;
`ifdef SERIAL_ALU_ZFLAG_EN
  logic             zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .cout      (cout)
`ifdef SERIAL_ALU_ZFLAG_EN
    ,.zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode meaning.
  task automatic model(input logic [1:0] op, input int unsigned x, input int unsigned y,
                       output int unsigned r, output int unsigned c);
    int unsigned full;
    case (op)
      2'd0: begin full = x + y; r = full % (1 << WIDTH); c = (full >= (1 << WIDTH)) ? 1 : 0; end
      2'd1: begin r = (x + (1 << WIDTH) - y) % (1 << WIDTH); c = (x < y) ? 1 : 0; end
      2'd2: begin r = x & y; c = 0; end
      default: begin r = x | y; c = 0; end
    endcase
  endtask

  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input int hold);
    int unsigned er, ec;
    int lat;
    model(op, x, y, er, ec);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; s = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) begin
        in_valid = 1'($urandom);
        a = WIDTH'($urandom); b = WIDTH'($urandom);
      end
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
    end
    in_valid = 1'b0;
    check("latency", lat, WIDTH);
    if (lat == 0) begin
      rst = 1'b1; #1; rst = 1'b0;
      return;
    end
    check("result", R, er);
    check("cout", cout, ec);
`ifdef SERIAL_ALU_ZFLAG_EN
    check("zero", zero, (er == 0) ? 1 : 0);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; s = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", R, er);
      check("hold_cout", cout, ec);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("consumed_valid", out_valid, 0);
    check("no_accept_on_consume", in_ready, 1);
  endtask

  initial begin
    int highs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s = 2'd0; a = '0; b = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_R", R, 0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ALU_ZFLAG_EN
    check("rst_zero", zero, 0);
`endif
    #11 rst = 1'b0;
    @(posedge clk); #1;

    do_op(2'd0, 8'h0F, 8'h01, 0);
    do_op(2'd0, 8'hFF, 8'h01, 1);
    do_op(2'd1, 8'h03, 8'h05, 0);
    do_op(2'd1, 8'h05, 8'h03, 2);
    do_op(2'd2, 8'hCC, 8'hAA, 0);
    do_op(2'd3, 8'hCC, 8'hAA, 5);

    // Abort mid-RUN: reset after bit 4 is in flight must drop the request.
    in_valid = 1'b1; s = 2'd0; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_R", R, 0);
    check("abort_cout", cout, 0);
    #1 rst = 1'b0;
    highs = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid) highs++;
    end
    check("abort_no_result", highs, 0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0]       op;
      logic [WIDTH-1:0] x, y;
      op = 2'($urandom);
      x  = WIDTH'($urandom);
      y  = WIDTH'($urandom);
      if (t % 8 == 0) y = x;
      do_op(op, x, y, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
